// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: request/launch/wait/commit sequencer for the shared mult/div unit
//   clk, reset (async active-low)
//   req/op/a_in/b_in   : request from control unit, sampled only in IDLE
//   abort              : synchronous cancel, returns to IDLE without any pulse
//   unit_done          : completion strobe from the unit, honoured only in WAIT
//   unit_start/op/a/b  : launch pulse and latched request to the unit
//   load_hilo/done/div_zero/timeout : one-cycle result pulses
//   busy, last_cycles  : status
module muldiv_sequencer #(
    parameter int TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        op,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    input  logic        abort,
    input  logic        unit_done,
    output logic        unit_start,
    output logic        unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        load_hilo,
    output logic        done,
    output logic        div_zero,
    output logic        timeout,
    output logic        busy,
    output logic [7:0]  last_cycles
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, COMMIT, ZERO_EXC, FAULT} state_t;
    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d, last_q, last_d;
    logic        op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            op_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    op_d    = op;
                    a_d     = a_in;
                    b_d     = b_in;
                    state_d = (op && b_in == '0) ? ZERO_EXC : LAUNCH;
                end
                LAUNCH: begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end
                WAIT: begin
                    if (unit_done) begin
                        state_d = COMMIT;
                        last_d  = cnt_q + 8'd1;
                    end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                        state_d = FAULT;
                        last_d  = 8'(TIMEOUT);
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    assign unit_start  = state_q == LAUNCH;
    assign load_hilo   = state_q == COMMIT;
    assign div_zero    = state_q == ZERO_EXC;
    assign timeout     = state_q == FAULT;
    assign done        = state_q == COMMIT || state_q == ZERO_EXC || state_q == FAULT;
    assign busy        = state_q != IDLE;
    assign unit_op     = op_q;
    assign unit_a      = a_q;
    assign unit_b      = b_q;
    assign last_cycles = last_q;
endmodule
